// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Valid/ready pipeline stage register with 2-entry skid buffer,
//            flush and bubble insertion; optional stall counter enabled by
//            macro PIPE_STALL_STAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;

    // Handshake outputs come from registered state only, never from out_ready.
    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign data_out  = r_main_data;
    assign ctrl_out  = w_out_valid ? r_main_ctrl : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_main_data <= data_in;
                        r_main_ctrl <= ctrl_in;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= data_in;
                        r_main_ctrl <= ctrl_in;
                    end else if (w_in_fire) begin
                        r_state     <= ST_FULL;
                        r_skid_data <= data_in;
                        r_skid_ctrl <= ctrl_in;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_state     <= ST_ONE;
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                    end
                end
                // Encoding 3 is unreachable; fall back to a clean empty stage.
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

`ifdef PIPE_STALL_STAT_EN
    logic [STAT_W-1:0] r_stall_cnt;

    // Saturating count of cycles the head entry waited on downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Scoreboard bench for pipe_stage_skid (stall counter checked
//            against PIPE_STALL_STAT_EN build setting).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    localparam int DW = 96;
    localparam int CW = 4;
    localparam int SW = 4;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_in = '0;
    logic [CW-1:0] ctrl_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic [CW-1:0] ctrl_out;
    logic [SW-1:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int model_stall = 0;

    logic [DW+CW-1:0] exp_q[$];
    logic [DW+CW-1:0] obs_q[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .STAT_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .ctrl_in   (ctrl_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .ctrl_out  (ctrl_out),
        .stall_cnt (stall_cnt)
    );

    // Advance one clock: record accepted/emitted entries and the stall model
    // from the pre-edge handshake, then return 1 time unit after the edge.
    task automatic step();
        #2;
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({data_in, ctrl_in});
        if (out_valid && out_ready) obs_q.push_back({data_out, ctrl_out});
`ifdef PIPE_STALL_STAT_EN
        if (out_valid && !out_ready && model_stall < STALL_MAX) model_stall++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #4;
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        model_stall = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = DW'(32'h55);
        ctrl_in   = 4'h3;
        step();
        in_valid = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_total++;
        if (ctrl_out !== '0) $display("FAIL reset_ctrl_out: got %h want 0", ctrl_out);
        else n_pass++;
        n_total++;
        if (data_out !== '0) $display("FAIL reset_data_out: got %h want 0", data_out);
        else n_pass++;
        n_total++;
        if (stall_cnt !== '0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        else n_pass++;
        #3;
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        model_stall = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        logic [DW+CW-1:0] e;
        logic [DW+CW-1:0] o;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            data_in  = DW'(i);
            ctrl_in  = 4'hF;
            step();
            n_total++;
            if (out_valid !== 1'b1 || data_out !== DW'(i) || in_ready !== 1'b1)
                $display("FAIL stream_latency[%0d]: got v=%b d=%h r=%b want v=1 d=%h r=1",
                         i, out_valid, data_out, in_ready, DW'(i));
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
        n_total++;
        if (obs_q.size() !== 5 || exp_q.size() !== 5)
            $display("FAIL stream_count: got obs=%0d exp=%0d want 5", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL stream_order: got %h want %h", o, e);
            else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [DW+CW-1:0] e;
        logic [DW+CW-1:0] o;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl_in   = 4'h1;
        data_in   = DW'(32'hA);
        step();
        data_in = DW'(32'hB);
        step();
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== DW'(32'hA))
            $display("FAIL bp_full: got r=%b v=%b d=%h want r=0 v=1 d=a", in_ready, out_valid, data_out);
        else n_pass++;
        data_in = DW'(32'hC);
        step();
        n_total++;
        if (in_ready !== 1'b0 || data_out !== DW'(32'hA) || exp_q.size() !== 2)
            $display("FAIL bp_reject: got r=%b d=%h accepted=%0d want r=0 d=a accepted=2",
                     in_ready, data_out, exp_q.size());
        else n_pass++;
        n_total++;
        if (stall_cnt !== SW'(model_stall))
            $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt, model_stall);
        else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_total++;
        if (obs_q.size() !== 3 || exp_q.size() !== 3)
            $display("FAIL bp_count: got obs=%0d exp=%0d want 3", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_total++;
            if (o !== e || o[DW+CW-1:CW] !== DW'(32'hA + i))
                $display("FAIL bp_order[%0d]: got %h want %h", i, o, e);
            else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_flush();
        logic [DW+CW-1:0] o;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl_in   = 4'h6;
        data_in   = DW'(32'hA);
        step();
        data_in = DW'(32'hB);
        step();
        flush   = 1'b1;
        data_in = DW'(32'hD);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || ctrl_out !== '0 || in_ready !== 1'b1)
            $display("FAIL flush_empty: got v=%b c=%h r=%b want v=0 c=0 r=1", out_valid, ctrl_out, in_ready);
        else n_pass++;
        n_total++;
        if (data_out !== DW'(32'hA))
            $display("FAIL flush_payload_kept: got %h want a", data_out);
        else n_pass++;
        n_total++;
        if (stall_cnt !== SW'(model_stall))
            $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, model_stall);
        else n_pass++;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = DW'(32'hE);
        step();
        in_valid = 1'b0;
        step();
        n_total++;
        if (obs_q.size() !== 1)
            $display("FAIL flush_count: got %0d entries want 1", obs_q.size());
        else n_pass++;
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_total++;
            if (o !== {DW'(32'hE), 4'h6})
                $display("FAIL flush_next: got %h want %h", o, {DW'(32'hE), 4'h6});
            else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = DW'(32'h77);
        ctrl_in   = 4'b1011;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || ctrl_out !== 4'b1011)
            $display("FAIL bubble_valid_ctrl: got v=%b c=%b want v=1 c=1011", out_valid, ctrl_out);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0 || ctrl_out !== '0 || data_out !== DW'(32'h77))
            $display("FAIL bubble_idle: got v=%b c=%b d=%h want v=0 c=0 d=77", out_valid, ctrl_out, data_out);
        else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stall_stat();
        do_reset();
        n_total++;
        if (stall_cnt !== '0) $display("FAIL stall_after_reset: got %0d want 0", stall_cnt);
        else n_pass++;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = DW'(32'h9);
        ctrl_in   = 4'h2;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_total++;
`ifdef PIPE_STALL_STAT_EN
        if (model_stall !== 5 || stall_cnt !== SW'(5))
`else
        if (model_stall !== 0 || stall_cnt !== '0)
`endif
            $display("FAIL stall_partial: got %0d model %0d", stall_cnt, model_stall);
        else n_pass++;
        for (int i = 0; i < 15; i++) step();
        n_total++;
`ifdef PIPE_STALL_STAT_EN
        if (stall_cnt !== SW'(STALL_MAX))
            $display("FAIL stall_saturate: got %0d want %0d", stall_cnt, STALL_MAX);
`else
        if (stall_cnt !== '0)
            $display("FAIL stall_disabled: got %0d want 0", stall_cnt);
`endif
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== SW'(model_stall))
            $display("FAIL stall_drain: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, stall_cnt, model_stall);
        else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #1;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_stall_stat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule

`default_nettype wire
